count_up_stopwatch: RTL and testbench

- Elapsed-time counterpart of the game countdown timer: counts up in BCD from 0:00.0 while the game runs.
- Freezes on game over. Raises a flag when a programmable target time is reached. Saturates at 9:59.9.
- Sits beside the countdown timer and feeds the score/HUD seven-segment path with M:SS.d digits.
- Single synchronous clock domain. 100 ms advance comes from a one-cycle tick enable, not a derived clock.

---
 rtl/timer_pkg.sv | 49 ++++
 rtl/bcd_digit_counter.sv | 33 +++
 rtl/count_up_stopwatch.sv | 152 +++++++++++++++
 tb/tb_count_up_stopwatch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the game timer blocks: FSM states, BCD digit type,
// packed M:SS.d time value and the target-to-digits conversion.
package timer_pkg;

  typedef enum logic [2:0] {IDLE, RUN, PAUSED, HALT, SAT} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  typedef struct packed {
    bcd_t min;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t ds;
  } time_t;

  // Binary seconds (clamped to 59) split into BCD tens/ones by a compare
  // chain rather than a divider.
  function automatic time_t target_digits(input bcd_t tmin, input logic [5:0] tsec);
    logic [5:0] s;
    time_t      t;
    s     = (tsec > 6'd59) ? 6'd59 : tsec;
    t.min = tmin;
    t.ds  = '0;
    if (s >= 6'd50) begin
      t.sec_tens = 4'd5;
      s          = s - 6'd50;
    end else if (s >= 6'd40) begin
      t.sec_tens = 4'd4;
      s          = s - 6'd40;
    end else if (s >= 6'd30) begin
      t.sec_tens = 4'd3;
      s          = s - 6'd30;
    end else if (s >= 6'd20) begin
      t.sec_tens = 4'd2;
      s          = s - 6'd20;
    end else if (s >= 6'd10) begin
      t.sec_tens = 4'd1;
      s          = s - 6'd10;
    end else begin
      t.sec_tens = 4'd0;
    end
    t.sec_ones = s[3:0];
    return t;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with programmable modulus. carry reports that an increment
// is arriving at the terminal value; hold suppresses the update so the
// parent can freeze the whole chain on saturation without a loop.
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       hold,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MODULUS - 1);

  assign carry = inc && (q == LAST);

  // Digit register: synchronous clear wins over increment; wraps at LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !hold) begin
      q <= carry ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/count_up_stopwatch.sv
// Count-up BCD stopwatch (M:SS.d) advanced by a 100 ms tick enable.
// Optional lap capture registers are built when STOPWATCH_LAP_EN is defined.
module count_up_stopwatch
  import timer_pkg::*;
#(
  parameter int unsigned MAX_MIN      = 9,
  parameter int unsigned TICKS_PER_DS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       game_over,
  input  logic [3:0] target_min,
  input  logic [5:0] target_sec,
  output logic [3:0] min_out,
  output logic [3:0] sec_tens_out,
  output logic [3:0] sec_ones_out,
  output logic [3:0] ds_out,
  output logic       running,
  output logic       target_hit,
  output logic       sat_flag
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic       lap,
  output logic [3:0] lap_min,
  output logic [3:0] lap_sec_tens,
  output logic [3:0] lap_sec_ones,
  output logic [3:0] lap_ds,
  output logic       lap_valid
`endif
);

  localparam logic [3:0] PRESC_LAST = 4'(TICKS_PER_DS - 1);

  state_t     state, next_state;
  logic [3:0] presc, presc_next;
  logic       due;
  logic       sat_hit;
  logic       c_ds, c_ones, c_tens;
  time_t      cnt, tgt;
  logic       tgt_nonzero;

  // An increment is due only in RUN when no higher-priority control is active.
  assign due = (state == RUN) && !clear && !game_over && !pause &&
               tick_100ms && (presc == PRESC_LAST);

  bcd_digit_counter #(.MODULUS(DIGIT_MAX + 1)) u_ds (
    .clk(clk), .rst(rst), .clr(clear), .inc(due), .hold(sat_hit),
    .q(ds_out), .carry(c_ds)
  );

  bcd_digit_counter #(.MODULUS(DIGIT_MAX + 1)) u_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_ds), .hold(sat_hit),
    .q(sec_ones_out), .carry(c_ones)
  );

  bcd_digit_counter #(.MODULUS(SEC_TENS_MAX + 1)) u_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_ones), .hold(sat_hit),
    .q(sec_tens_out), .carry(c_tens)
  );

  // Carry out of the minute digit means the count is at MAX_MIN:59.9 with
  // an increment due, i.e. saturation.
  bcd_digit_counter #(.MODULUS(MAX_MIN + 1)) u_min (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_tens), .hold(sat_hit),
    .q(min_out), .carry(sat_hit)
  );

  assign cnt         = {min_out, sec_tens_out, sec_ones_out, ds_out};
  assign tgt         = target_digits(target_min, target_sec);
  assign tgt_nonzero = (tgt.min != '0) || (tgt.sec_tens != '0) || (tgt.sec_ones != '0);

  // Next-state and prescaler logic, priority clear > game_over > pause > start > tick.
  always_comb begin
    next_state = state;
    presc_next = presc;
    if (clear) begin
      presc_next = '0;
      // A held game_over keeps HALT latched even through clear.
      next_state = (state == HALT && game_over) ? HALT : IDLE;
    end else if (game_over && (state inside {IDLE, RUN, PAUSED})) begin
      next_state = HALT;
    end else begin
      case (state)
        IDLE:   if (start) next_state = RUN;
        RUN: begin
          if (pause) begin
            next_state = PAUSED;
          end else if (tick_100ms) begin
            if (due) begin
              presc_next = '0;
              if (sat_hit) next_state = SAT;
            end else begin
              presc_next = presc + 4'd1;
            end
          end
        end
        PAUSED: if (start) next_state = RUN;
        default: ;
      endcase
    end
  end

  // State, prescaler and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      running    <= 1'b0;
      target_hit <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      state   <= next_state;
      presc   <= presc_next;
      running <= (next_state == RUN);
      if (clear) begin
        target_hit <= 1'b0;
        sat_flag   <= 1'b0;
      end else begin
        if (due && sat_hit) sat_flag <= 1'b1;
        if (state == RUN && tgt_nonzero && cnt == tgt) target_hit <= 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  time_t lap_q;

  // Lap capture samples the registered (pre-increment) count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q     <= '0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_q     <= '0;
      lap_valid <= 1'b0;
    end else if (lap && state == RUN) begin
      lap_q     <= cnt;
      lap_valid <= 1'b1;
    end
  end

  assign lap_min      = lap_q.min;
  assign lap_sec_tens = lap_q.sec_tens;
  assign lap_sec_ones = lap_q.sec_ones;
  assign lap_ds       = lap_q.ds;
`endif

endmodule

// File: tb/tb_count_up_stopwatch.sv
// Directed testbench for count_up_stopwatch: default, MAX_MIN=1 and
// TICKS_PER_DS=3 instances. Lap checks are built with STOPWATCH_LAP_EN.
`timescale 1ns/1ps
module tb_count_up_stopwatch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick0 = 1'b0, tick1 = 1'b0, tick2 = 1'b0;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0, game_over = 1'b0;
  logic [3:0] target_min = '0;
  logic [5:0] target_sec = '0;

  logic [3:0] m0, st0, so0, d0, m1, st1, so1, d1, m2, st2, so2, d2;
  logic       run0, hit0, sat0, run1, hit1, sat1, run2, hit2, sat2;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  logic       lap = 1'b0;
  logic [3:0] lm, lst, lso, lds;
  logic       lvalid;
  logic       lap1, lap2;
  logic [3:0] lm1, lst1, lso1, lds1, lm2, lst2, lso2, lds2;
  logic       lvalid1, lvalid2;
`endif

  count_up_stopwatch #(.MAX_MIN(9), .TICKS_PER_DS(1)) dut0 (
    .clk(clk), .rst(rst), .tick_100ms(tick0), .start(start), .pause(pause),
    .clear(clear), .game_over(game_over), .target_min(target_min), .target_sec(target_sec),
    .min_out(m0), .sec_tens_out(st0), .sec_ones_out(so0), .ds_out(d0),
    .running(run0), .target_hit(hit0), .sat_flag(sat0)
`ifdef STOPWATCH_LAP_EN
    , .lap(lap), .lap_min(lm), .lap_sec_tens(lst), .lap_sec_ones(lso), .lap_ds(lds),
    .lap_valid(lvalid)
`endif
  );

  count_up_stopwatch #(.MAX_MIN(1), .TICKS_PER_DS(1)) dut1 (
    .clk(clk), .rst(rst), .tick_100ms(tick1), .start(start), .pause(pause),
    .clear(clear), .game_over(game_over), .target_min(target_min), .target_sec(target_sec),
    .min_out(m1), .sec_tens_out(st1), .sec_ones_out(so1), .ds_out(d1),
    .running(run1), .target_hit(hit1), .sat_flag(sat1)
`ifdef STOPWATCH_LAP_EN
    , .lap(lap1), .lap_min(lm1), .lap_sec_tens(lst1), .lap_sec_ones(lso1), .lap_ds(lds1),
    .lap_valid(lvalid1)
`endif
  );

  count_up_stopwatch #(.MAX_MIN(9), .TICKS_PER_DS(3)) dut2 (
    .clk(clk), .rst(rst), .tick_100ms(tick2), .start(start), .pause(pause),
    .clear(clear), .game_over(game_over), .target_min(target_min), .target_sec(target_sec),
    .min_out(m2), .sec_tens_out(st2), .sec_ones_out(so2), .ds_out(d2),
    .running(run2), .target_hit(hit2), .sat_flag(sat2)
`ifdef STOPWATCH_LAP_EN
    , .lap(lap2), .lap_min(lm2), .lap_sec_tens(lst2), .lap_sec_ones(lso2), .lap_ds(lds2),
    .lap_valid(lvalid2)
`endif
  );

`ifdef STOPWATCH_LAP_EN
  assign lap1 = 1'b0;
  assign lap2 = 1'b0;
`endif

  logic [15:0] t0, t1, t2;
  assign t0 = {m0, st0, so0, d0};
  assign t1 = {m1, st1, so1, d1};
  assign t2 = {m2, st2, so2, d2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; @(negedge clk); pause = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  // n back-to-back single-cycle ticks on the selected instance.
  task automatic ticks(input int unsigned which, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      case (which)
        0: tick0 = 1'b1;
        1: tick1 = 1'b1;
        default: tick2 = 1'b1;
      endcase
      @(negedge clk);
      tick0 = 1'b0; tick1 = 1'b0; tick2 = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_time", 32'(t0), 32'h0000);
    check("rst_flags", {29'd0, run0, hit0, sat0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic count: 25 ticks -> 0:02.5
    pulse_start();
    ticks(0, 25);
    check("run25_time", 32'(t0), 32'h0025);
    check("run25_flags", {29'd0, run0, hit0, sat0}, 32'b100);

    // Target 0:03 hit timing and stickiness
    pulse_clear();
    check("clear_time", 32'(t0), 32'h0000);
    target_sec = 6'd3;
    pulse_start();
    ticks(0, 29);
    check("tgt29_hit", 32'(hit0), 32'd0);
    ticks(0, 1);
    check("tgt30_time", 32'(t0), 32'h0030);
    check("tgt30_hit_early", 32'(hit0), 32'd0);
    @(negedge clk);
    check("tgt30_hit", 32'(hit0), 32'd1);
    ticks(0, 5);
    check("tgt35_time", 32'(t0), 32'h0035);
    check("tgt35_hit", 32'(hit0), 32'd1);
    target_sec = 6'd0;
    @(negedge clk);
    check("tgt_change_sticky", 32'(hit0), 32'd1);

    // Pause / resume, then game_over freeze
    pulse_clear();
    check("clear_hit", 32'(hit0), 32'd0);
    pulse_start();
    ticks(0, 12);
    pulse_pause();
    ticks(0, 20);
    check("paused_time", 32'(t0), 32'h0012);
    check("paused_run", 32'(run0), 32'd0);
    pulse_start();
    ticks(0, 3);
    check("resume_time", 32'(t0), 32'h0015);
    game_over = 1'b1;
    @(negedge clk);
    ticks(0, 10);
    pulse_start();
    ticks(0, 2);
    check("halt_time", 32'(t0), 32'h0015);
    check("halt_run", 32'(run0), 32'd0);
    game_over = 1'b0;
    pulse_start();
    ticks(0, 2);
    check("halt_needs_clear", 32'(t0), 32'h0015);
    pulse_clear();
    check("halt_clear_time", 32'(t0), 32'h0000);

    // Target seconds above 59 clamp to 59
    target_sec = 6'd61;
    pulse_start();
    ticks(0, 589);
    check("clamp_589_hit", 32'(hit0), 32'd0);
    ticks(0, 1);
    check("clamp_590_time", 32'(t0), 32'h0590);
    @(negedge clk);
    check("clamp_hit", 32'(hit0), 32'd1);
    target_sec = 6'd0;
    pulse_clear();

    // Saturation with MAX_MIN=1
    pulse_start();
    ticks(1, 1199);
    check("sat_pre_time", 32'(t1), 32'h1599);
    check("sat_pre_flags", {29'd0, run1, hit1, sat1}, 32'b100);
    ticks(1, 1);
    check("sat_time", 32'(t1), 32'h1599);
    check("sat_flags", {29'd0, run1, hit1, sat1}, 32'b001);
    pulse_start();
    ticks(1, 3);
    check("sat_hold_time", 32'(t1), 32'h1599);
    check("sat_hold_run", 32'(run1), 32'd0);
    pulse_clear();
    check("sat_clear_time", 32'(t1), 32'h0000);
    check("sat_clear_flags", {29'd0, run1, hit1, sat1}, 32'd0);

    // Prescaler with TICKS_PER_DS=3
    pulse_start();
    ticks(2, 7);
    check("presc7_time", 32'(t2), 32'h0002);
    ticks(2, 1);
    check("presc8_time", 32'(t2), 32'h0002);
    ticks(2, 1);
    check("presc9_time", 32'(t2), 32'h0003);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clr_start_time", 32'(t2), 32'h0000);
    check("clr_start_run", 32'(run2), 32'd0);
    ticks(2, 3);
    check("clr_start_idle", 32'(t2), 32'h0000);

`ifdef STOPWATCH_LAP_EN
    // Lap captures the pre-increment value
    pulse_clear();
    pulse_start();
    ticks(0, 47);
    check("lap_before", 32'(lvalid), 32'd0);
    tick0 = 1'b1; lap = 1'b1;
    @(negedge clk);
    tick0 = 1'b0; lap = 1'b0;
    check("lap_value", {16'd0, lm, lst, lso, lds}, 32'h0047);
    check("lap_count", 32'(t0), 32'h0048);
    check("lap_valid", 32'(lvalid), 32'd1);
    pulse_clear();
    check("lap_cleared", {15'd0, lvalid, lm, lst, lso, lds}, 32'd0);
`endif

    // Asynchronous reset mid-run, away from any clock edge
    pulse_clear();
    pulse_start();
    ticks(0, 14);
    check("pre_async_time", 32'(t0), 32'h0014);
    #2 rst = 1'b0;
    #1;
    check("async_rst_time", 32'(t0), 32'h0000);
    check("async_rst_run", 32'(run0), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
